bus_sequencer: RTL
==================

BUS_SEQUENCER -- requirements
Module: bus_sequencer

Interface
REQ-001 Parameter MEM_WAIT, default 2, memory access cycles per read/write (legal range 1..15).
REQ-002 Clk  in  1  system clock; all state updates on rising edge.
REQ-003 Reset  in  1  synchronous, active-high; one clock; forces state HALTED.
REQ-004 Run  in  1  start request, sampled in HALTED.
REQ-005 Continue  in  1  resume from PAUSE, level-sensitive.
REQ-006 Opcode  in  4  IR[15:12].
REQ-007 IR_5  in  1  IR[5], immediate-select for ADD/AND.
REQ-008 BEN  in  1  registered branch-enable from datapath.
REQ-009 GatePC, GateMARMUX, GateMDR, GateALU  out  1 each  bus drive enables for the 16-bit shared bus.
REQ-010 LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED  out  1 each  register loads.
REQ-011 PCMUX  out  2  00 PC+1, 01 bus, 10 address adder.
REQ-012 ADDR1MUX  out  1  0 PC, 1 SR1; ADDR2MUX  out  2  00 zero, 01 off6, 10 off9, 11 off11.
REQ-013 SR1MUX  out  1  0 IR[11:9], 1 IR[8:6]; SR2MUX  out  1  0 register, 1 imm5; DRMUX  out  1  0 IR[11:9], 1 R7.
REQ-014 ALUK  out  2  00 ADD, 01 AND, 10 NOT, 11 PASS A.
REQ-015 Mem_OE_n, Mem_WE_n  out  1 each  active-low memory read/write strobes.

Function
REQ-016 Outputs SHALL be combinational from state; every output not named for a state SHALL be 0 (Mem_OE_n/Mem_WE_n 1, muxes 00/0).
REQ-017 At most one Gate* SHALL be 1 in any cycle; HALTED, PAUSE and memory-wait states drive no Gate*.
REQ-018 HALTED: stay while Run=0; Run=1 -> FETCH1.
REQ-019 FETCH1: GatePC, LD_MAR, PCMUX=00, LD_PC -> FETCH2.
REQ-020 FETCH2: Mem_OE_n=0 for exactly MEM_WAIT cycles; LD_MDR=1 on last cycle only -> FETCH3.
REQ-021 FETCH3: GateMDR, LD_IR -> DECODE.
REQ-022 DECODE: LD_BEN; next by Opcode: 0001/0101/1001 ALU, 0000 BR0, 1100 JMP, 0110 LDR1, 0111 STR1, 1101 PAUSE1, any other -> FETCH1.
REQ-023 ALU (1 cycle): SR1MUX=1, SR2MUX=IR_5, DRMUX=0, ALUK=00/01/10 for ADD/AND/NOT, GateALU, LD_REG, LD_CC -> FETCH1.
REQ-024 BR0: BEN=1 -> BR1, else FETCH1; BR1: ADDR1MUX=0, ADDR2MUX=10, PCMUX=10, LD_PC -> FETCH1.
REQ-025 JMP: SR1MUX=1, ADDR1MUX=1, ADDR2MUX=00, PCMUX=10, LD_PC -> FETCH1.
REQ-026 LDR1: SR1MUX=1, ADDR1MUX=1, ADDR2MUX=01, GateMARMUX, LD_MAR -> LDR2 (read wait per REQ-020) -> LDR3: GateMDR, DRMUX=0, LD_REG, LD_CC -> FETCH1.
REQ-027 STR1 as LDR1 -> STR2: SR1MUX=0, ALUK=11, GateALU, LD_MDR -> STR3: Mem_WE_n=0 for exactly MEM_WAIT cycles -> FETCH1.
REQ-028 PAUSE1: LD_LED=1; stay while Continue=0, Continue=1 -> PAUSE2; stay while Continue=1, Continue=0 -> FETCH1.
REQ-029 Wait counter: 4-bit, loaded MEM_WAIT-1 on entry to a memory state, decrements each cycle, exit when 0; MEM_WAIT=1 gives single-cycle access.
REQ-030 Run is ignored outside HALTED; Continue ignored outside PAUSE1/PAUSE2.

Reset
REQ-031 Reset=1 at any edge, including mid-memory-wait, SHALL give state HALTED, counter 0, all Gate*/LD_* 0, Mem_OE_n=Mem_WE_n=1 next cycle; Reset dominates Run.

Verification
REQ-032 Reset, Run=1 one cycle, Opcode=0001, MEM_WAIT=2 -> FETCH1,FETCH2x2,FETCH3,DECODE,ALU; LD_MDR only on 2nd FETCH2 cycle; GateALU+LD_REG+LD_CC on cycle 6.
REQ-033 Opcode=0000, BEN=0 then BEN=1 -> BR0->FETCH1 (no LD_PC); BR0->BR1 with PCMUX=10, LD_PC=1.
REQ-034 Opcode=0111, MEM_WAIT=3 -> Mem_WE_n=0 exactly 3 cycles in STR3, GateALU with LD_MDR in STR2.
REQ-035 Opcode=1101: Continue=0 5 cycles, 1 for 2, 0 -> LD_LED high 5+ cycles in PAUSE1, then PAUSE2, then FETCH1.
REQ-036 Reset asserted in 1st FETCH2 cycle -> HALTED next cycle, Mem_OE_n=1, no LD_MDR pulse.
REQ-037 All runs: assertion that popcount(Gate*) <= 1 every cycle; Opcode=1111 -> DECODE->FETCH1.

Source files
------------

// File: rtl/bus_sequencer.sv
// rtl/bus_sequencer.sv - multi-cycle control sequencer for a 16-bit shared-bus datapath
module bus_sequencer #(
  parameter int MEM_WAIT = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       Continue,
  input  logic [3:0] Opcode,
  input  logic       IR_5,
  input  logic       BEN,
  output logic       GatePC,
  output logic       GateMARMUX,
  output logic       GateMDR,
  output logic       GateALU,
  output logic       LD_MAR,
  output logic       LD_MDR,
  output logic       LD_IR,
  output logic       LD_BEN,
  output logic       LD_CC,
  output logic       LD_REG,
  output logic       LD_PC,
  output logic       LD_LED,
  output logic [1:0] PCMUX,
  output logic       ADDR1MUX,
  output logic [1:0] ADDR2MUX,
  output logic       SR1MUX,
  output logic       SR2MUX,
  output logic       DRMUX,
  output logic [1:0] ALUK,
  output logic       Mem_OE_n,
  output logic       Mem_WE_n
);

  typedef enum logic [4:0] {
    S_HALTED,
    S_FETCH1,
    S_FETCH2,
    S_FETCH3,
    S_DECODE,
    S_ALU,
    S_BR0,
    S_BR1,
    S_JMP,
    S_LDR1,
    S_LDR2,
    S_LDR3,
    S_STR1,
    S_STR2,
    S_STR3,
    S_PAUSE1,
    S_PAUSE2
  } state_t;

  // Memory states last wait_cnt+1 cycles; reload value makes the access MEM_WAIT cycles long.
  localparam logic [3:0] WAIT_INIT = 4'(MEM_WAIT - 1);

  state_t     state;
  state_t     state_next;
  logic [3:0] wait_cnt;
  logic       load_wait;
  logic       wait_done;

  assign wait_done = (wait_cnt == 4'd0);

  // State register; reset parks the sequencer in HALTED with an empty wait counter.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= S_HALTED;
    end else begin
      state <= state_next;
    end
  end

  // Wait counter: reloaded on the transition into a memory state, then counts down to zero.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      wait_cnt <= 4'd0;
    end else if (load_wait) begin
      wait_cnt <= WAIT_INIT;
    end else if (!wait_done) begin
      wait_cnt <= wait_cnt - 4'd1;
    end
  end

  // Next-state selection and per-state control outputs; everything idles unless named below.
  always_comb begin
    state_next = state;
    load_wait  = 1'b0;
    GatePC     = 1'b0;
    GateMARMUX = 1'b0;
    GateMDR    = 1'b0;
    GateALU    = 1'b0;
    LD_MAR     = 1'b0;
    LD_MDR     = 1'b0;
    LD_IR      = 1'b0;
    LD_BEN     = 1'b0;
    LD_CC      = 1'b0;
    LD_REG     = 1'b0;
    LD_PC      = 1'b0;
    LD_LED     = 1'b0;
    PCMUX      = 2'b00;
    ADDR1MUX   = 1'b0;
    ADDR2MUX   = 2'b00;
    SR1MUX     = 1'b0;
    SR2MUX     = 1'b0;
    DRMUX      = 1'b0;
    ALUK       = 2'b00;
    Mem_OE_n   = 1'b1;
    Mem_WE_n   = 1'b1;

    case (state)
      S_HALTED: begin
        if (Run) begin
          state_next = S_FETCH1;
        end
      end

      S_FETCH1: begin
        GatePC     = 1'b1;
        LD_MAR     = 1'b1;
        PCMUX      = 2'b00;
        LD_PC      = 1'b1;
        load_wait  = 1'b1;
        state_next = S_FETCH2;
      end

      S_FETCH2: begin
        Mem_OE_n = 1'b0;
        if (wait_done) begin
          LD_MDR     = 1'b1;
          state_next = S_FETCH3;
        end
      end

      S_FETCH3: begin
        GateMDR    = 1'b1;
        LD_IR      = 1'b1;
        state_next = S_DECODE;
      end

      S_DECODE: begin
        LD_BEN = 1'b1;
        case (Opcode)
          4'b0001, 4'b0101, 4'b1001: state_next = S_ALU;
          4'b0000:                   state_next = S_BR0;
          4'b1100:                   state_next = S_JMP;
          4'b0110:                   state_next = S_LDR1;
          4'b0111:                   state_next = S_STR1;
          4'b1101:                   state_next = S_PAUSE1;
          default:                   state_next = S_FETCH1;
        endcase
      end

      S_ALU: begin
        SR1MUX  = 1'b1;
        SR2MUX  = IR_5;
        DRMUX   = 1'b0;
        GateALU = 1'b1;
        LD_REG  = 1'b1;
        LD_CC   = 1'b1;
        case (Opcode)
          4'b0101: ALUK = 2'b01;
          4'b1001: ALUK = 2'b10;
          default: ALUK = 2'b00;
        endcase
        state_next = S_FETCH1;
      end

      S_BR0: begin
        state_next = BEN ? S_BR1 : S_FETCH1;
      end

      S_BR1: begin
        ADDR1MUX   = 1'b0;
        ADDR2MUX   = 2'b10;
        PCMUX      = 2'b10;
        LD_PC      = 1'b1;
        state_next = S_FETCH1;
      end

      S_JMP: begin
        SR1MUX     = 1'b1;
        ADDR1MUX   = 1'b1;
        ADDR2MUX   = 2'b00;
        PCMUX      = 2'b10;
        LD_PC      = 1'b1;
        state_next = S_FETCH1;
      end

      S_LDR1, S_STR1: begin
        SR1MUX     = 1'b1;
        ADDR1MUX   = 1'b1;
        ADDR2MUX   = 2'b01;
        GateMARMUX = 1'b1;
        LD_MAR     = 1'b1;
        if (state == S_LDR1) begin
          load_wait  = 1'b1;
          state_next = S_LDR2;
        end else begin
          state_next = S_STR2;
        end
      end

      S_LDR2: begin
        Mem_OE_n = 1'b0;
        if (wait_done) begin
          LD_MDR     = 1'b1;
          state_next = S_LDR3;
        end
      end

      S_LDR3: begin
        GateMDR    = 1'b1;
        DRMUX      = 1'b0;
        LD_REG     = 1'b1;
        LD_CC      = 1'b1;
        state_next = S_FETCH1;
      end

      S_STR2: begin
        SR1MUX     = 1'b0;
        ALUK       = 2'b11;
        GateALU    = 1'b1;
        LD_MDR     = 1'b1;
        load_wait  = 1'b1;
        state_next = S_STR3;
      end

      S_STR3: begin
        Mem_WE_n = 1'b0;
        if (wait_done) begin
          state_next = S_FETCH1;
        end
      end

      S_PAUSE1: begin
        LD_LED = 1'b1;
        if (Continue) begin
          state_next = S_PAUSE2;
        end
      end

      S_PAUSE2: begin
        if (!Continue) begin
          state_next = S_FETCH1;
        end
      end

      default: begin
        state_next = S_HALTED;
      end
    endcase
  end

endmodule
